mem_access_ctrl: RTL

- Multicycle sequencer for all data-memory accesses: lw/lh/lb loads and sw/sh/sb stores.
- Accepts one request from the main control unit and drives the synchronous data memory with a fixed read latency.
- For loads, presents the captured word plus a LoadOp select (0 word, 1 half, 2 byte) to the load-extension unit.
- Performs read-modify-write for half/byte stores, with sub-word data in the low lanes.

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Multicycle sequencer for data-memory accesses (lw/lh/lb loads, sw/sh/sb
// stores). One request is accepted at a time from the main control unit.
// The sequencer drives a synchronous data memory whose read data is valid
// MEM_LAT cycles after the read-strobe cycle. Half/byte stores are done as
// read-modify-write, with the sub-word operand in the low lanes.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       request strobe, only looked at while idle
//   op          0 lw, 1 lh, 2 lb, 4 sw, 5 sh, 6 sb (3 and 7 are illegal)
//   addr        byte address, captured with start
//   store_data  store operand, captured with start
//   mem_rdata   memory read data
//   mem_addr    memory address (holds until the next accepted request)
//   mem_re      memory read strobe
//   mem_we      memory write strobe
//   mem_wdata   memory write data
//   load_data   captured read word for the load-extension unit
//   load_op     load-extension select: 0 word, 1 half, 2 byte
//   load_en     one-cycle pulse, load result valid
//   busy        request in progress
//   done        one-cycle completion pulse
//   op_err      illegal-op flag, pulses together with done
//
// Every output is a flop. Each output is set on the edge that enters the
// state it belongs to, so the output is high exactly while the FSM sits in
// that state.
module mem_access_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic [1:0]  load_op,
    output logic        load_en,
    output logic        busy,
    output logic        done,
    output logic        op_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_FMT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] sdata_q;
    logic [3:0]  cnt_q;
    logic [31:0] mem_addr_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_data_q;
    logic [1:0]  load_op_q;
    logic        load_en_q;
    logic        busy_q;
    logic        done_q;
    logic        op_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            sdata_q     <= 32'd0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            load_op_q   <= 2'd0;
            load_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            // Strobes default low; only the state-entry edge raises them.
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            load_en_q <= 1'b0;
            done_q    <= 1'b0;
            op_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        sdata_q    <= store_data;
                        mem_addr_q <= addr;
                        busy_q     <= 1'b1;
                        case (op)
                            3'd4: begin
                                // A full-word store needs no read.
                                state_q     <= S_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= store_data;
                            end
                            3'd0, 3'd1, 3'd2, 3'd5, 3'd6: begin
                                state_q  <= S_READ;
                                mem_re_q <= 1'b1;
                            end
                            default: begin
                                // Illegal op: no memory traffic at all.
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                op_err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        load_data_q <= mem_rdata;
                        if (op_q[2]) begin
                            // Merge from mem_rdata directly: it is the same
                            // word being captured into load_data this edge.
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= (op_q == 3'd5) ?
                                           {mem_rdata[31:16], sdata_q[15:0]} :
                                           {mem_rdata[31:8],  sdata_q[7:0]};
                        end else begin
                            state_q   <= S_FMT;
                            load_en_q <= 1'b1;
                            load_op_q <= op_q[1:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FMT, S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;
    assign load_op   = load_op_q;
    assign load_en   = load_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign op_err    = op_err_q;

endmodule
